// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- byte-wide UART transmitter with valid/ready handshake.
//
// Frames one byte as: start bit (0), 8 data bits LSB first, optional parity
// bit, then STOP_BITS stop bits (1). Every line bit lasts CLK_HZ/BAUD_RATE
// clock cycles. The serial line idles high.
//
// Parameters
//   CLK_HZ      system clock frequency in Hz
//   BAUD_RATE   line bit rate in bits/s
//   PARITY_EN   1 = append a parity bit after the data bits
//   PARITY_ODD  0 = even parity, 1 = odd parity (only used with PARITY_EN=1)
//   STOP_BITS   number of stop bits, 1 or 2
//
// Ports
//   clk_in     in   system clock, rising edge
//   rst_in     in   synchronous active-high reset
//   data_in    in   [7:0] byte to send, captured on the handshake edge
//   valid_in   in   upstream has a byte for us
//   ready_out  out  a byte is accepted on this edge if valid_in=1 (combinational)
//   tx_out     out  serial line, registered
//   busy_out   out  high while a frame is on the line, registered
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int CLK_HZ     = 65_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx_out,
  output logic       busy_out
);

  localparam int BIT_CYCLES = CLK_HZ / BAUD_RATE;
  // Counter never narrower than 16 bits; grows for very slow baud rates.
  localparam int CNT_W_MIN  = $clog2(BIT_CYCLES);
  localparam int CNT_W      = (CNT_W_MIN > 16) ? CNT_W_MIN : 16;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  // Value of the stop-bit index during the final stop bit.
  localparam logic STOP_LAST  = (STOP_BITS == 2);
  localparam logic PAR_INVERT = (PARITY_ODD != 0);
  localparam logic PAR_USED   = (PARITY_EN != 0);

  generate
    if (BIT_CYCLES < 2) begin : g_bad_baud
      $error("uart_tx: CLK_HZ/BAUD_RATE must be at least 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
      $error("uart_tx: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic             r_stop_idx;
  logic [7:0]       r_shift;
  logic             r_tx;
  logic             r_busy;

  state_t           w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [2:0]       w_idx_next;
  logic             w_stop_next;
  logic [7:0]       w_shift_next;
  logic             w_tx_next;
  logic             w_busy_next;

  logic             w_cnt_zero;
  logic             w_parity;
  logic             w_ready;

  assign w_cnt_zero = (r_cnt == '0);
  // The latched byte is held unchanged for the whole frame, so parity can be
  // taken straight from it.
  assign w_parity   = (^r_shift) ^ PAR_INVERT;
  assign w_ready    = (r_state == IDLE) && !rst_in;

  assign ready_out  = w_ready;
  assign tx_out     = r_tx;
  assign busy_out   = r_busy;

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic. tx and busy are computed for the state we
  // are entering so that they come out of flops aligned with the state.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_stop_next  = r_stop_idx;
    w_shift_next = r_shift;
    w_tx_next    = r_tx;
    w_busy_next  = r_busy;

    // Bit timer: runs in every non-idle state, reloading as each bit ends.
    if (r_state != IDLE) begin
      w_cnt_next = w_cnt_zero ? CNT_RELOAD : (r_cnt - CNT_ONE);
    end

    case (r_state)
      IDLE: begin
        w_tx_next   = 1'b1;
        w_busy_next = 1'b0;
        if (valid_in && w_ready) begin
          w_state_next = START;
          w_cnt_next   = CNT_RELOAD;
          w_shift_next = data_in;
          w_idx_next   = 3'd0;
          w_tx_next    = 1'b0;
          w_busy_next  = 1'b1;
        end
      end

      START: begin
        if (w_cnt_zero) begin
          w_state_next = DATA;
          w_idx_next   = 3'd0;
          w_tx_next    = r_shift[0];
        end
      end

      DATA: begin
        if (w_cnt_zero) begin
          if (r_idx == 3'd7) begin
            w_idx_next = 3'd0;
            if (PAR_USED) begin
              w_state_next = PARITY;
              w_tx_next    = w_parity;
            end else begin
              w_state_next = STOP;
              w_stop_next  = 1'b0;
              w_tx_next    = 1'b1;
            end
          end else begin
            w_idx_next = r_idx + 3'd1;
            w_tx_next  = r_shift[r_idx + 3'd1];
          end
        end
      end

      PARITY: begin
        if (w_cnt_zero) begin
          w_state_next = STOP;
          w_stop_next  = 1'b0;
          w_tx_next    = 1'b1;
        end
      end

      STOP: begin
        if (w_cnt_zero) begin
          if (r_stop_idx == STOP_LAST) begin
            w_state_next = IDLE;
            w_tx_next    = 1'b1;
            w_busy_next  = 1'b0;
          end else begin
            w_stop_next = 1'b1;
          end
        end
      end

      default: begin
        w_state_next = IDLE;
        w_tx_next    = 1'b1;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register. Reset aborts any frame in progress and parks the line high.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_idx      <= 3'd0;
      r_stop_idx <= 1'b0;
      r_shift    <= 8'h00;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_idx      <= w_idx_next;
      r_stop_idx <= w_stop_next;
      r_shift    <= w_shift_next;
      r_tx       <= w_tx_next;
      r_busy     <= w_busy_next;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx -- bench for uart_tx.
//
// Four transmitters run side by side at 10 clocks per bit:
//   inst 0: 8N1, inst 1: 8E1, inst 2: 8O1, inst 3: 8N2.
// Each has a frame-level model (frame active? position in frame? which byte?)
// that is compared against tx/busy/ready on every falling edge. Directed tests
// additionally capture frames and pin a few hand-computed values.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  localparam int BC = 10;  // 1 MHz / 100 kbaud

  logic       clk;
  logic [3:0] rst_v;
  logic [3:0] valid_v;
  logic [7:0] data_a [4];
  logic [3:0] ready_v;
  logic [3:0] tx_v;
  logic [3:0] busy_v;

  int n_total = 0;
  int n_bad   = 0;

  logic cap_tx    [0:255];
  logic cap_busy  [0:255];
  logic cap_ready [0:255];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int inst,
                       input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s inst=%0d got=%0h want=%0h t=%0t", name, inst, got, want, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // DUTs plus a per-instance frame model and every-cycle comparator.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_inst
    localparam int PE   = (gi == 1 || gi == 2) ? 1 : 0;
    localparam int PO   = (gi == 2) ? 1 : 0;
    localparam int SB   = (gi == 3) ? 2 : 1;
    localparam int FLEN = (9 + PE + SB) * BC;

    uart_tx #(
      .CLK_HZ    (1_000_000),
      .BAUD_RATE (100_000),
      .PARITY_EN (PE),
      .PARITY_ODD(PO),
      .STOP_BITS (SB)
    ) u_dut (
      .clk_in   (clk),
      .rst_in   (rst_v[gi]),
      .data_in  (data_a[gi]),
      .valid_in (valid_v[gi]),
      .ready_out(ready_v[gi]),
      .tx_out   (tx_v[gi]),
      .busy_out (busy_v[gi])
    );

    bit         m_active = 1'b0;
    int         m_pos    = 0;
    logic [7:0] m_byte   = 8'h00;

    // A frame is FLEN cycles long starting right after an accepted byte.
    always @(posedge clk) begin
      if (rst_v[gi]) begin
        m_active <= 1'b0;
        m_pos    <= 0;
      end else if (m_active) begin
        if (m_pos == FLEN - 1) m_active <= 1'b0;
        m_pos <= m_pos + 1;
      end else if (valid_v[gi]) begin
        m_active <= 1'b1;
        m_pos    <= 0;
        m_byte   <= data_a[gi];
      end
    end

    always @(negedge clk) begin
      int   bitn;
      logic e_tx;
      e_tx = 1'b1;
      bitn = 0;
      if (m_active) begin
        bitn = m_pos / BC;
        if (bitn == 0)                   e_tx = 1'b0;
        else if (bitn <= 8)              e_tx = m_byte[bitn-1];
        else if (PE == 1 && bitn == 9)   e_tx = (^m_byte) ^ (PO != 0);
        else                             e_tx = 1'b1;
      end
      check("model_tx",    gi, 32'(tx_v[gi]),    32'(e_tx));
      check("model_busy",  gi, 32'(busy_v[gi]),  32'(m_active));
      check("model_ready", gi, 32'(ready_v[gi]), 32'(!m_active && !rst_v[gi]));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Inputs change 1 time unit after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic send(input int i, input logic [7:0] b);
    @(posedge clk); #1;
    valid_v[i] = 1'b1;
    data_a[i]  = b;
    @(posedge clk); #1;  // handshake edge just passed
    valid_v[i] = 1'b0;
    data_a[i]  = ~b;     // must not disturb the frame
    $display("send inst=%0d data=%02h t=%0t", i, b, $time);
  endtask

  // Records n cycles; index k is frame cycle k when called right after send().
  task automatic capture(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cap_tx[k]    = tx_v[i];
      cap_busy[k]  = busy_v[i];
      cap_ready[k] = ready_v[i];
    end
  endtask

  function automatic int count_tx(input int a, input int b, input logic v);
    int c = 0;
    for (int k = a; k <= b; k++) if (cap_tx[k] === v) c++;
    return c;
  endfunction

  function automatic int count_busy(input int a, input int b);
    int c = 0;
    for (int k = a; k <= b; k++) if (cap_busy[k] === 1'b1) c++;
    return c;
  endfunction

  task automatic wait_idle(input int i);
    int n = 0;
    while (ready_v[i] !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", i, 32'(ready_v[i]), 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin
    int high_cnt;
    rst_v   = 4'hF;
    valid_v = 4'h0;
    for (int i = 0; i < 4; i++) data_a[i] = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tx",    0, 32'(tx_v[0]),    32'd1);
    check("rst_busy",  0, 32'(busy_v[0]),  32'd0);
    check("rst_ready", 0, 32'(ready_v[0]), 32'd0);
    @(posedge clk); #1;
    rst_v = 4'h0;
    @(negedge clk);
    check("rel_ready", 0, 32'(ready_v[0]), 32'd1);

    // 8N1 0xA5: bits LSB first 1,0,1,0,0,1,0,1
    send(0, 8'hA5);
    capture(0, 110);
    check("a5_start0",  0, 32'(cap_tx[0]),    32'd0);
    check("a5_start9",  0, 32'(cap_tx[9]),    32'd0);
    check("a5_d0",      0, 32'(cap_tx[10]),   32'd1);
    check("a5_d1",      0, 32'(cap_tx[20]),   32'd0);
    check("a5_d2",      0, 32'(cap_tx[35]),   32'd1);
    check("a5_d4",      0, 32'(cap_tx[55]),   32'd0);
    check("a5_d7",      0, 32'(cap_tx[89]),   32'd1);
    check("a5_stop",    0, 32'(cap_tx[95]),   32'd1);
    check("a5_busycnt", 0, 32'(count_busy(0, 109)), 32'd100);
    check("a5_ready",   0, 32'(cap_ready[100]), 32'd1);

    // 8E1 0x07: three ones -> even parity bit 1
    send(1, 8'h07);
    capture(1, 120);
    check("e07_d2",     1, 32'(cap_tx[35]),  32'd1);
    check("e07_d7",     1, 32'(cap_tx[85]),  32'd0);
    check("e07_par",    1, 32'(cap_tx[95]),  32'd1);
    check("e07_busy",   1, 32'(count_busy(0, 119)), 32'd110);

    // 8O1 0x07: odd parity bit 0
    send(2, 8'h07);
    capture(2, 120);
    check("o07_par",    2, 32'(cap_tx[95]),  32'd0);
    check("o07_busy",   2, 32'(count_busy(0, 119)), 32'd110);

    // 8N2 0x00: 90 low then 20 high
    send(3, 8'h00);
    capture(3, 120);
    check("n2_high",    3, 32'(count_tx(0, 109, 1'b1)), 32'd20);
    check("n2_low",     3, 32'(count_tx(0, 89, 1'b0)),  32'd90);
    check("n2_stop2",   3, 32'(cap_tx[105]),  32'd1);
    check("n2_busy",    3, 32'(count_busy(0, 119)), 32'd110);
    check("n2_end",     3, 32'(cap_busy[110]), 32'd0);

    // Back-to-back with valid held high: 0x00 then 0xFF
    @(posedge clk); #1;
    valid_v[0] = 1'b1;
    data_a[0]  = 8'h00;
    @(posedge clk); #1;
    data_a[0]  = 8'hFF;
    $display("send inst=0 data=00 then FF held valid t=%0t", $time);
    capture(0, 150);
    @(posedge clk); #1;
    valid_v[0] = 1'b0;
    check("b2b_low0",   0, 32'(count_tx(0, 89, 1'b0)), 32'd90);
    check("b2b_stop",   0, 32'(cap_tx[99]),    32'd1);
    check("b2b_gap_tx", 0, 32'(cap_tx[100]),   32'd1);
    check("b2b_gap_rd", 0, 32'(cap_ready[100]), 32'd1);
    check("b2b_gap_bz", 0, 32'(cap_busy[100]), 32'd0);
    check("b2b_start",  0, 32'(cap_tx[101]),   32'd0);
    check("b2b_start9", 0, 32'(cap_tx[110]),   32'd0);
    check("b2b_ff",     0, 32'(count_tx(111, 149, 1'b1)), 32'd39);
    wait_idle(0);

    // Reset at frame cycle 35 of 0x00 (data bit 2)
    send(0, 8'h00);
    repeat (35) @(posedge clk);
    #1;
    rst_v[0]   = 1'b1;
    valid_v[0] = 1'b1;  // ignored during reset
    data_a[0]  = 8'h3C;
    $display("reset inst=0 mid-frame t=%0t", $time);
    @(negedge clk);
    check("mr_pre_tx",  0, 32'(tx_v[0]),    32'd0);
    check("mr_pre_rdy", 0, 32'(ready_v[0]), 32'd0);
    @(negedge clk);
    check("mr_tx",      0, 32'(tx_v[0]),    32'd1);
    check("mr_busy",    0, 32'(busy_v[0]),  32'd0);
    check("mr_ready",   0, 32'(ready_v[0]), 32'd0);
    @(posedge clk); #1;
    rst_v[0]   = 1'b0;
    valid_v[0] = 1'b0;
    @(negedge clk);
    check("mr_rel_rdy", 0, 32'(ready_v[0]), 32'd1);
    high_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (tx_v[0] === 1'b1 && busy_v[0] === 1'b0) high_cnt++;
    end
    check("mr_quiet",   0, 32'(high_cnt), 32'd30);

    // valid pulsed with 0x3C while 0x5A is on the line
    send(0, 8'h5A);
    fork
      capture(0, 130);
      begin
        repeat (20) @(posedge clk);
        #1;
        valid_v[0] = 1'b1;
        data_a[0]  = 8'h3C;
        @(posedge clk); #1;
        valid_v[0] = 1'b0;
      end
    join
    check("ig_d0",      0, 32'(cap_tx[15]),  32'd0);
    check("ig_d1",      0, 32'(cap_tx[25]),  32'd1);
    check("ig_d3",      0, 32'(cap_tx[45]),  32'd1);
    check("ig_busy",    0, 32'(count_busy(0, 99)),   32'd100);
    check("ig_nobusy",  0, 32'(count_busy(100, 129)), 32'd0);
    check("ig_line",    0, 32'(count_tx(100, 129, 1'b1)), 32'd30);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
